// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller and the decoder that consumes its digit codes.
package ssd_pkg;

  localparam logic [4:0] SSD_OFF = 5'h1F;

  typedef logic [4:0] ssd_code_t;

  // A counter that must hold the value 0 still needs a 1-bit register, so the result is at least 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ssd_refresh_div.sv
// Free-running slot divider. slot_tick is high on the last cycle of each REFRESH_DIV-cycle digit slot.
module ssd_refresh_div
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_tick
);

  localparam int CW = clog2_min1(REFRESH_DIV);

  logic [CW-1:0] r_div_cnt;

  assign slot_tick = (r_div_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (slot_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display with tear-free word commit.
// Optional leading-zero blanking is enabled by defining SSD_LEAD_ZERO_BLANK_EN.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_en,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  output ssd_code_t               number,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_tick
);

  localparam int IDX_W = clog2_min1(NUM_DIGITS);

  logic [IDX_W-1:0]        r_dig_idx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;

  logic                    w_slot_tick;
  logic                    w_last_digit;
  logic                    w_commit;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_sel_onehot;

  ssd_refresh_div #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_tick(w_slot_tick)
  );

  // Load handshake: a word transfers on any cycle where load_valid && load_ready. load_ready
  // is low while a word waits in the shadow register; the requester must hold load_data stable.
  assign load_ready   = !r_pending;
  assign w_last_digit = (r_dig_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_commit     = w_slot_tick && w_last_digit && r_pending;
  assign w_nib        = r_active[4*r_dig_idx +: 4];
  assign w_sel_onehot = NUM_DIGITS'(1) << r_dig_idx;

`ifdef SSD_LEAD_ZERO_BLANK_EN
  // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
  always_comb begin
    w_blank = '0;
    w_blank[NUM_DIGITS-1] = (r_active[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
      w_blank[i] = w_blank[i+1] && (r_active[4*i +: 4] == 4'h0);
    end
    w_blank[0] = 1'b0;
  end
`else
  assign w_blank = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_idx   <= '0;
      r_active    <= '0;
      r_shadow    <= '0;
      r_pending   <= 1'b0;
      number      <= SSD_OFF;
      digit_sel_n <= '1;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= w_commit;

      if (w_slot_tick) begin
        r_dig_idx <= w_last_digit ? '0 : r_dig_idx + 1'b1;
      end

      // Commit only ever happens while pending, when load_ready is low, so it cannot collide with a transfer.
      if (w_commit) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (load_valid && load_ready) begin
        r_shadow  <= load_data;
        r_pending <= 1'b1;
      end

      if (disp_en) begin
        digit_sel_n <= ~w_sel_onehot;
        number      <= w_blank[r_dig_idx] ? SSD_OFF : {1'b0, w_nib};
      end else begin
        digit_sel_n <= '1;
        number      <= SSD_OFF;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        disp_en;
  logic [15:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  number;
  logic [3:0]  digit_sel_n;
  logic        frame_tick;

  int n_checks;
  int n_errs;

  typedef struct {
    logic [15:0]     data;
    logic [3:0][4:0] exp_off;
    logic [3:0][4:0] exp_blk;
  } vec_t;

  vec_t vecs[5];

  ssd_scan_ctrl #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_en    (disp_en),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .number     (number),
    .digit_sel_n(digit_sel_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][4:0] sel_exp(input vec_t v);
`ifdef SSD_LEAD_ZERO_BLANK_EN
    return v.exp_blk;
`else
    return v.exp_off;
`endif
  endfunction

  task automatic load_word(input logic [15:0] data);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (load_ready) seen = 1;
    end
    chk("load_ready_seen", 32'(seen), 32'd1);
    load_data  = data;
    load_valid = 1'b1;
    @(posedge clk); #1;
    chk("load_ready_drop", 32'(load_ready), 32'd0);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_frame_tick(input bit chk_busy);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (frame_tick) got = 1;
      else if (chk_busy) chk("busy_ready", 32'(load_ready), 32'd0);
    end
    chk("frame_tick_seen", 32'(got), 32'd1);
  endtask

  // Called right after the frame_tick sample; checks the 16 cycles of the frame that follows.
  task automatic check_frame(input logic [3:0][4:0] codes, input logic exp_rdy,
                             input logic exp_last_tick);
    logic [3:0] es;
    int d;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      d  = k / 4;
      es = 4'b0001 << d;
      es = ~es;
      chk("frame_sel", 32'(digit_sel_n), 32'(es));
      chk("frame_num", 32'(number), 32'(codes[d]));
      chk("frame_tick", 32'(frame_tick), (k == 15) ? 32'(exp_last_tick) : 32'd0);
      chk("frame_ready", 32'(load_ready), (k == 15) ? 32'd1 : 32'(exp_rdy));
      if (k == 0) begin
        @(negedge clk);
        load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int ticks;
    bit got;
    n_checks = 0;
    n_errs   = 0;

    vecs[0] = '{16'h12AB, {5'h01, 5'h02, 5'h0A, 5'h0B}, {5'h01, 5'h02, 5'h0A, 5'h0B}};
    vecs[1] = '{16'h0070, {5'h00, 5'h00, 5'h07, 5'h00}, {5'h1F, 5'h1F, 5'h07, 5'h00}};
    vecs[2] = '{16'h0000, {5'h00, 5'h00, 5'h00, 5'h00}, {5'h1F, 5'h1F, 5'h1F, 5'h00}};
    vecs[3] = '{16'h0100, {5'h00, 5'h01, 5'h00, 5'h00}, {5'h1F, 5'h01, 5'h00, 5'h00}};
    vecs[4] = '{16'hF00F, {5'h0F, 5'h00, 5'h00, 5'h0F}, {5'h0F, 5'h00, 5'h00, 5'h0F}};

    rst_n      = 1'b0;
    disp_en    = 1'b1;
    load_data  = '0;
    load_valid = 1'b0;

    // Reset state, then the first registered digit after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_number", 32'(number), 32'h1F);
    chk("rst_sel", 32'(digit_sel_n), 32'hF);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_number", 32'(number), 32'h00);
    chk("post_rst_sel", 32'(digit_sel_n), 32'hE);

    // Table: load, commit at frame boundary, then scan digits 0..3 for 4 cycles each.
    for (int v = 0; v < 5; v++) begin
      load_word(vecs[v].data);
      wait_frame_tick(1'b1);
      chk("tick_ready", 32'(load_ready), 32'd1);
      check_frame(sel_exp(vecs[v]), 1'b1, 1'b0);
    end

    // Second word held on load_valid while the first is pending.
    load_word(16'h1111);
    @(negedge clk);
    load_data  = 16'h2222;
    load_valid = 1'b1;
    wait_frame_tick(1'b1);
    chk("hold_tick_ready", 32'(load_ready), 32'd1);
    check_frame({5'h01, 5'h01, 5'h01, 5'h01}, 1'b0, 1'b1);
    check_frame({5'h02, 5'h02, 5'h02, 5'h02}, 1'b1, 1'b0);

    // Blank mid-slot, commit while blanked, then resume in step with the scan.
    @(negedge clk);
    disp_en = 1'b0;
    @(posedge clk); #1;
    chk("blank_number", 32'(number), 32'h1F);
    chk("blank_sel", 32'(digit_sel_n), 32'hF);
    load_word(16'h5A3C);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      chk("blank_hold_number", 32'(number), 32'h1F);
      chk("blank_hold_sel", 32'(digit_sel_n), 32'hF);
      if (frame_tick) got = 1;
    end
    chk("blank_commit_seen", 32'(got), 32'd1);
    @(negedge clk);
    disp_en = 1'b1;
    check_frame({5'h05, 5'h0A, 5'h03, 5'h0C}, 1'b1, 1'b0);

    // Asynchronous reset with a word pending: it must never reach the display.
    load_word(16'h9999);
    chk("pre_rst_pending", 32'(load_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_number", 32'(number), 32'h1F);
    chk("async_rst_sel", 32'(digit_sel_n), 32'hF);
    chk("async_rst_ready", 32'(load_ready), 32'd1);
    chk("async_rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      chk("post_rst_digit", 32'(number), 32'h00);
      if (frame_tick) ticks++;
    end
    chk("post_rst_no_commit", 32'(ticks), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
